// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset controller: states,
// opcodes, mux select codes and the control-word struct.
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EX     = 4'd6,
    S_R_WB     = 4'd7,
    S_BEQ      = 4'd8,
    S_JMP      = 4'd9,
    S_ADDI_EX  = 4'd10,
    S_ADDI_WB  = 4'd11,
    S_TRAP     = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_SUB   = 2'd1;
  localparam logic [1:0] ALU_FUNCT = 2'd2;

  localparam logic [1:0] SRCB_RT      = 2'd0;
  localparam logic [1:0] SRCB_FOUR    = 2'd1;
  localparam logic [1:0] SRCB_IMM     = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_word_t;

endpackage

// File: rtl/multicycle_control_ctrl_word_decode.sv
// Moore control-word decoder: state in, datapath enables and mux selects out.
module ctrl_word_decode
  import multicycle_ctrl_pkg::*;
(
  input  state_e     i_state,
  output ctrl_word_t o_cw
);

  always_comb begin
    o_cw = '0;
    case (i_state)
      S_FETCH: begin
        o_cw.mem_read  = 1'b1;
        o_cw.ir_write  = 1'b1;
        o_cw.alu_src_b = SRCB_FOUR;
        o_cw.alu_op    = ALU_ADD;
        o_cw.pc_source = PCSRC_ALU;
        o_cw.pc_write  = 1'b1;
      end
      // Branch target is precomputed here while the opcode is dispatched.
      S_DECODE:   o_cw.alu_src_b = SRCB_IMM_SH2;
      S_MEM_ADDR: begin
        o_cw.alu_src_a = 1'b1;
        o_cw.alu_src_b = SRCB_IMM;
      end
      S_MEM_RD: begin
        o_cw.mem_read = 1'b1;
        o_cw.iord     = 1'b1;
      end
      S_MEM_WB: begin
        o_cw.reg_write  = 1'b1;
        o_cw.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        o_cw.mem_write = 1'b1;
        o_cw.iord      = 1'b1;
      end
      S_R_EX: begin
        o_cw.alu_src_a = 1'b1;
        o_cw.alu_src_b = SRCB_RT;
        o_cw.alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        o_cw.reg_write = 1'b1;
        o_cw.reg_dst   = 1'b1;
      end
      S_BEQ: begin
        o_cw.alu_src_a     = 1'b1;
        o_cw.alu_src_b     = SRCB_RT;
        o_cw.alu_op        = ALU_SUB;
        o_cw.pc_write_cond = 1'b1;
        o_cw.pc_source     = PCSRC_ALUOUT;
      end
      S_JMP: begin
        o_cw.pc_write  = 1'b1;
        o_cw.pc_source = PCSRC_JUMP;
      end
      S_ADDI_EX: begin
        o_cw.alu_src_a = 1'b1;
        o_cw.alu_src_b = SRCB_IMM;
      end
      S_ADDI_WB: o_cw.reg_write = 1'b1;
      default:   o_cw = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle sequencing controller: state register, dispatch, sticky Illegal,
// reset gating of strobes and PC_En. Optional MEM_WAIT_EN stalls memory states.
module multicycle_control
  import multicycle_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 6,
  parameter int STATE_W  = 4
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [OPCODE_W-1:0] i_opcode,
  input  logic                i_zero,
  input  logic                i_mem_ready,
  output logic                o_pc_en,
  output logic                o_iord,
  output logic                o_mem_read,
  output logic                o_mem_write,
  output logic                o_ir_write,
  output logic                o_reg_dst,
  output logic                o_mem_to_reg,
  output logic                o_reg_write,
  output logic                o_alu_src_a,
  output logic [1:0]          o_alu_src_b,
  output logic [1:0]          o_alu_op,
  output logic [1:0]          o_pc_source,
  output logic [STATE_W-1:0]  o_state,
  output logic                o_illegal
);

  state_e     r_state, w_next, w_dec_state;
  ctrl_word_t w_cw;
  logic       r_illegal;
  logic       w_mem_ok;
  logic       w_fetch_gate;

`ifdef MEM_WAIT_EN
  assign w_mem_ok = i_mem_ready;
`else
  logic w_unused_mem_ready;
  assign w_unused_mem_ready = i_mem_ready;
  assign w_mem_ok           = 1'b1;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= S_FETCH;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next == S_TRAP) r_illegal <= 1'b1;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH: w_next = w_mem_ok ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (i_opcode)
          OP_RTYPE:     w_next = S_R_EX;
          OP_LW, OP_SW: w_next = S_MEM_ADDR;
          OP_BEQ:       w_next = S_BEQ;
          OP_J:         w_next = S_JMP;
          OP_ADDI:      w_next = S_ADDI_EX;
          default:      w_next = S_TRAP;
        endcase
      end
      // Opcode is re-read here; anything other than lw/sw is treated as illegal.
      S_MEM_ADDR: begin
        case (i_opcode)
          OP_LW:   w_next = S_MEM_RD;
          OP_SW:   w_next = S_MEM_WR;
          default: w_next = S_TRAP;
        endcase
      end
      S_MEM_RD:  w_next = w_mem_ok ? S_MEM_WB : S_MEM_RD;
      S_MEM_WR:  w_next = w_mem_ok ? S_FETCH : S_MEM_WR;
      S_R_EX:    w_next = S_R_WB;
      S_ADDI_EX: w_next = S_ADDI_WB;
      S_MEM_WB, S_R_WB, S_BEQ, S_JMP, S_ADDI_WB: w_next = S_FETCH;
      S_TRAP:    w_next = S_TRAP;
      default:   w_next = S_FETCH;
    endcase
  end

  // During reset the outputs show the FETCH decode with all strobes gated off.
  assign w_dec_state = i_reset ? S_FETCH : r_state;

  ctrl_word_decode u_dec (
    .i_state (w_dec_state),
    .o_cw    (w_cw)
  );

  // A stalled fetch must not advance the PC or reload IR.
  assign w_fetch_gate = (w_dec_state == S_FETCH) ? w_mem_ok : 1'b1;

  assign o_pc_en      = ~i_reset & ((w_cw.pc_write & w_fetch_gate) | (w_cw.pc_write_cond & i_zero));
  assign o_ir_write   = ~i_reset & w_cw.ir_write & w_fetch_gate;
  assign o_mem_read   = ~i_reset & w_cw.mem_read;
  assign o_mem_write  = ~i_reset & w_cw.mem_write;
  assign o_reg_write  = ~i_reset & w_cw.reg_write;
  assign o_iord       = w_cw.iord;
  assign o_reg_dst    = w_cw.reg_dst;
  assign o_mem_to_reg = w_cw.mem_to_reg;
  assign o_alu_src_a  = w_cw.alu_src_a;
  assign o_alu_src_b  = w_cw.alu_src_b;
  assign o_alu_op     = w_cw.alu_op;
  assign o_pc_source  = w_cw.pc_source;
  assign o_state      = STATE_W'(w_dec_state);
  assign o_illegal    = r_illegal & ~i_reset;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed table-driven bench for multicycle_control; MEM_WAIT_EN adds a stall sequence.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst, zero, rdy;
  logic [5:0] op;
  logic       pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;
  logic       illegal;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  multicycle_control #(.OPCODE_W(6), .STATE_W(4)) dut (
    .i_clk(clk), .i_reset(rst), .i_opcode(op), .i_zero(zero), .i_mem_ready(rdy),
    .o_pc_en(pc_en), .o_iord(iord), .o_mem_read(mem_read), .o_mem_write(mem_write),
    .o_ir_write(ir_write), .o_reg_dst(reg_dst), .o_mem_to_reg(mem_to_reg),
    .o_reg_write(reg_write), .o_alu_src_a(alu_src_a), .o_alu_src_b(alu_src_b),
    .o_alu_op(alu_op), .o_pc_source(pc_source), .o_state(state), .o_illegal(illegal)
  );

  // Expected output word {state, pc_en, iord, mr, mw, irw, rd, m2r, rw, asa, asb, aop, ps, ill}
  function automatic logic [19:0] exp_word(int st, bit r, bit z, bit stall);
    logic pe, io, mr, mw, iw, rd, m2r, rw, sa, il;
    logic [1:0] sb, ao, ps;
    {pe, io, mr, mw, iw, rd, m2r, rw, sa, il} = '0;
    {sb, ao, ps} = '0;
    case (st)
      0:  begin mr = 1; iw = 1; sb = 1; pe = 1; end
      1:  sb = 3;
      2:  begin sa = 1; sb = 2; end
      3:  begin mr = 1; io = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mw = 1; io = 1; end
      6:  begin sa = 1; ao = 2; end
      7:  begin rw = 1; rd = 1; end
      8:  begin sa = 1; ao = 1; ps = 1; pe = z; end
      9:  begin pe = 1; ps = 2; end
      10: begin sa = 1; sb = 2; end
      11: rw = 1;
      12: il = 1;
      default: ;
    endcase
    if (stall) begin pe = 0; iw = 0; end
    if (r) begin pe = 0; iw = 0; mr = 0; mw = 0; rw = 0; end
    return {4'(st), pe, io, mr, mw, iw, rd, m2r, rw, sa, sb, ao, ps, il};
  endfunction

  task automatic step(string name, bit r, logic [5:0] o, bit z, bit rd_y, int st, bit stall);
    logic [19:0] act, expv;
    @(negedge clk);
    rst = r; op = o; zero = z; rdy = rd_y;
    #2;
    act  = {state, pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
            reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal};
    expv = exp_word(st, r, z, stall);
    nchk++;
    if (act !== expv) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  typedef struct {
    bit         r;
    logic [5:0] o;
    bit         z;
    int         st;
  } vec_t;

  vec_t vq[$];

  task automatic add(bit r, logic [5:0] o, bit z, int st);
    vec_t v;
    v.r = r; v.o = o; v.z = z; v.st = st;
    vq.push_back(v);
  endtask

  initial begin
    rst = 1; op = 0; zero = 0; rdy = 1;
    // reset held 3 cycles
    add(1, 6'h00, 0, 0); add(1, 6'h00, 1, 0); add(1, 6'h00, 0, 0);
    // R-type; opcode churn in R_EX/R_WB must be ignored
    add(0, 6'h00, 0, 0); add(0, 6'h00, 1, 1); add(0, 6'h3F, 0, 6); add(0, 6'h23, 1, 7);
    // lw
    add(0, 6'h23, 1, 0); add(0, 6'h23, 0, 1); add(0, 6'h23, 0, 2); add(0, 6'h00, 0, 3); add(0, 6'h00, 0, 4);
    // sw
    add(0, 6'h2B, 0, 0); add(0, 6'h2B, 0, 1); add(0, 6'h2B, 0, 2); add(0, 6'h2B, 0, 5);
    // beq taken, then not taken
    add(0, 6'h04, 0, 0); add(0, 6'h04, 0, 1); add(0, 6'h04, 1, 8);
    add(0, 6'h04, 1, 0); add(0, 6'h04, 1, 1); add(0, 6'h04, 0, 8);
    // j
    add(0, 6'h02, 0, 0); add(0, 6'h02, 0, 1); add(0, 6'h02, 0, 9);
    // addi
    add(0, 6'h08, 0, 0); add(0, 6'h08, 0, 1); add(0, 6'h08, 0, 10); add(0, 6'h08, 0, 11);
    // illegal opcode -> TRAP held 10 cycles regardless of inputs
    add(0, 6'h3F, 0, 0); add(0, 6'h3F, 0, 1);
    for (int i = 0; i < 10; i++) add(0, (i % 3 == 0) ? 6'h00 : 6'h02, bit'(i % 2), 12);
    // reset out of TRAP
    add(1, 6'h00, 0, 0);
    // R-type aborted by reset in R_WB, then a jump
    add(0, 6'h00, 0, 0); add(0, 6'h00, 0, 1); add(0, 6'h00, 0, 6); add(1, 6'h00, 0, 0);
    add(0, 6'h02, 0, 0); add(0, 6'h02, 0, 1); add(0, 6'h02, 0, 9); add(0, 6'h02, 0, 0);

    foreach (vq[i]) step($sformatf("vec%0d_st%0d", i, vq[i].st), vq[i].r, vq[i].o, vq[i].z, 1'b1, vq[i].st, 1'b0);

`ifdef MEM_WAIT_EN
    // fetch stalls 3 cycles, PC_En pulses once on Mem_Ready
    step("wait_rst", 1, 6'h00, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step($sformatf("wait_hold%0d", i), 0, 6'h00, 0, 0, 0, 1);
    step("wait_go", 0, 6'h00, 0, 1, 0, 0);
    step("wait_dec", 0, 6'h00, 0, 0, 1, 0);
`else
    // Mem_Ready ignored: fetch completes in one cycle
    step("nowait_rst", 1, 6'h00, 0, 0, 0, 0);
    step("nowait_fetch", 0, 6'h00, 0, 0, 0, 0);
    step("nowait_dec", 0, 6'h00, 0, 0, 1, 0);
    step("nowait_rex", 0, 6'h00, 0, 0, 6, 0);
`endif

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle sequencing controller for the MIPS-subset CPU datapath. Steps each instruction through fetch, decode, execute, memory and writeback states. Drives the PC, IR, memory, register-file and ALU mux enables that the single-cycle fetch/branch/jump path currently derives combinationally, so one memory and one ALU can be shared across cycles. Sits beside the datapath; its only datapath inputs are the IR opcode and the ALU Zero flag.

## Interface
- OPCODE_W, 6, opcode field width (Inst[31:26])
- STATE_W, 4, state register width

- Clock  in  1  rising-edge clock
- Reset  in  1  synchronous, active-high reset
- Opcode  in  OPCODE_W  IR[31:26], valid from DECODE onward
- Zero  in  1  ALU zero flag
- Mem_Ready  in  1  memory access complete (used only with MEM_WAIT_EN)
- PC_En  out  1  PC load = PC_Write | (PC_Write_Cond & Zero)
- IorD  out  1  memory address: 0 = PC, 1 = ALUOut
- Mem_Read / Mem_Write  out  1 each  memory strobes
- IR_Write  out  1  load IR from memory data
- Reg_Dst  out  1  write reg: 0 = rt, 1 = rd
- Mem_To_Reg  out  1  write data: 0 = ALUOut, 1 = MDR
- Reg_Write  out  1  register-file write enable
- ALU_Src_A  out  1  0 = PC, 1 = rs
- ALU_Src_B  out  2  0 = rt, 1 = const 4, 2 = sign-ext imm, 3 = sign-ext imm << 2
- ALU_Op  out  2  0 = add, 1 = sub, 2 = funct-decoded
- PC_Source  out  2  0 = ALU result, 1 = ALUOut, 2 = jump target
- State  out  STATE_W  current state, for debug
- Illegal  out  1  sticky illegal-opcode flag

## Operation
- States and encodings:
  - FETCH=0
  - DECODE=1
  - MEM_ADDR=2
  - MEM_RD=3
  - MEM_WB=4
  - MEM_WR=5
  - R_EX=6
  - R_WB=7
  - BEQ=8
  - JMP=9
  - ADDI_EX=10
  - ADDI_WB=11
  - TRAP=12
- FETCH
  - Outputs: Mem_Read=1, IorD=0, IR_Write=1, ALU_Src_A=0, ALU_Src_B=1, ALU_Op=0, PC_Source=0, PC_Write=1.
  - Next state: DECODE.
- DECODE
  - Outputs: ALU_Src_A=0, ALU_Src_B=3, ALU_Op=0 (precomputes branch target).
  - Dispatch on Opcode:
    - 000000 -> R_EX
    - 100011 or 101011 -> MEM_ADDR
    - 000100 -> BEQ
    - 000010 -> JMP
    - 001000 -> ADDI_EX
    - any other -> TRAP
- MEM_ADDR
  - Outputs: ALU_Src_A=1, ALU_Src_B=2, ALU_Op=0.
  - Next state: lw -> MEM_RD, sw -> MEM_WR.
- MEM_RD: Mem_Read=1, IorD=1. Next: MEM_WB.
- MEM_WB: Reg_Write=1, Reg_Dst=0, Mem_To_Reg=1. Next: FETCH.
- MEM_WR: Mem_Write=1, IorD=1. Next: FETCH.
- R_EX: ALU_Src_A=1, ALU_Src_B=0, ALU_Op=2. Next: R_WB.
- R_WB: Reg_Write=1, Reg_Dst=1, Mem_To_Reg=0. Next: FETCH.
- BEQ: ALU_Src_A=1, ALU_Src_B=0, ALU_Op=1, PC_Write_Cond=1, PC_Source=1. Next: FETCH.
- JMP: PC_Write=1, PC_Source=2. Next: FETCH.
- ADDI_EX: ALU_Src_A=1, ALU_Src_B=2, ALU_Op=0. Next: ADDI_WB.
- ADDI_WB: Reg_Write=1, Reg_Dst=0, Mem_To_Reg=0. Next: FETCH.
- TRAP
  - Illegal=1.
  - All enables and strobes are 0.
  - Stays in TRAP until Reset.
- Every output not listed for a state is 0.
- Outputs are Moore-decoded from the state register. PC_En is the only output that combines state with an input (Zero).
- Opcode is sampled only in DECODE and MEM_ADDR. Changes in other states are ignored.

## Timing
- Reset
  - Reset=1 at a rising edge: state <= FETCH, Illegal <= 0.
  - While Reset=1, PC_En, IR_Write, Mem_Read, Mem_Write and Reg_Write are forced to 0.
  - Every other output shows its FETCH decode.
  - First fetch occurs in the first cycle with Reset=0.
  - Reset in the middle of an instruction aborts it; no write strobe fires in the reset cycle.
- Cycles per instruction (without MEM_WAIT_EN):
  - R-type 4
  - lw 5
  - sw 4
  - beq 3
  - j 3
  - addi 4
- BEQ: PC_En equals Zero in the same cycle; the PC updates at the end of BEQ only if Zero=1.
- Reset has priority over all transitions, including TRAP.

## Configuration
- Macro: MEM_WAIT_EN.
- Defined:
  - FETCH, MEM_RD and MEM_WR hold their state and outputs while Mem_Ready=0.
  - They advance on the first edge where Mem_Ready=1.
  - In FETCH, PC_Write and IR_Write are qualified by Mem_Ready, so the PC increments exactly once per fetch.
- Undefined:
  - Mem_Ready is ignored and memory is treated as single-cycle.
  - Cycle counts are exactly as listed under Timing.

## Structure
- Package multicycle_ctrl_pkg:
  - state encodings
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI)
  - ALU_Op, ALU_Src_B and PC_Source codes
- Sub-module ctrl_word_decode: purely combinational state -> control-word decoder.
- The top level holds the state register, next-state logic, Illegal flag, reset gating and PC_En.

## Test plan
- Reset held 3 cycles, then released -> during reset State=0, all write strobes 0. In the first free cycle: Mem_Read=1, IR_Write=1, PC_En=1.
- Opcode 000000 presented from DECODE -> State sequence 0,1,6,7,0. Reg_Write=1 with Reg_Dst=1 only in state 7.
- Opcode 100011, then 101011 -> lw: 0,1,2,3,4,0 with Mem_To_Reg=1 in state 4. sw: 0,1,2,5,0 with Mem_Write=1 and IorD=1 in state 5.
- Opcode 000100 with Zero=1, then with Zero=0 -> PC_En=1 in BEQ for the first run, 0 for the second. Both return to FETCH after 3 cycles.
- Opcode 111111 -> TRAP, Illegal=1, no strobes for 10 cycles. Reset clears Illegal and restarts in FETCH. Reset asserted in R_WB -> Reg_Write=0 that cycle.
- MEM_WAIT_EN defined, Mem_Ready=0 for 3 cycles in FETCH -> State stays 0, PC_En=0. PC_En pulses once when Mem_Ready=1.
